// File: rtl/prism_cfg_sequencer.sv
// Burst loader for the PRISM state table: drains a small word FIFO into consecutive
// debug-port addresses while holding PRISM in reset, sharing the port with host writes.

module prism_cfg_sequencer #(
  parameter int FIFO_DEPTH  = 4,
  parameter int ADDR_W      = 6,
  parameter int HOLD_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [ADDR_W-1:0] i_host_addr,
  input  logic [31:0]       i_host_wdata,
  input  logic              i_host_wr,
  input  logic              i_ctrl_wr,
  input  logic [31:0]       i_ctrl_wdata,
  input  logic              i_fifo_wr,
  input  logic [31:0]       i_fifo_wdata,
  output logic [31:0]       o_status,
  output logic [ADDR_W-1:0] o_dbg_addr,
  output logic [31:0]       o_dbg_wdata,
  output logic              o_dbg_wr,
  output logic              o_prism_reset_req,
  output logic              o_prism_enable_req,
  output logic              o_done_irq
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_HOLD    = 2'd1,
    S_LOAD    = 2'd2,
    S_RELEASE = 2'd3
  } state_t;

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
  localparam logic [HW-1:0]     HOLD_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(4);

  state_t            r_state, w_next;
  logic [31:0]       r_mem [FIFO_DEPTH];
  logic [PW:0]       r_wrPtr, r_rdPtr, w_level;
  logic              w_empty, w_full, w_push, w_issue;
  logic              w_ctrlStart, w_ctrlAbort, w_ctrlClr, w_busy;
  logic [31:0]       w_head;
  logic [ADDR_W-1:0] r_curAddr;
  logic [5:0]        r_remaining;
  logic [HW-1:0]     r_holdCnt;
  logic              r_autoEn, r_enable, r_done, r_overflow, r_startErr;
  logic              w_unusedCtrl;

  assign w_ctrlAbort = i_ctrl_wr & i_ctrl_wdata[30];
  assign w_ctrlStart = i_ctrl_wr & i_ctrl_wdata[31] & ~i_ctrl_wdata[30];
  assign w_ctrlClr   = i_ctrl_wr & i_ctrl_wdata[29];
  assign w_unusedCtrl = ^{i_ctrl_wdata[28:17], i_ctrl_wdata[15:14],
                          i_ctrl_wdata[7:6], i_ctrl_wdata[1:0]};
  assign w_busy      = (r_state != S_IDLE);

  // Pointers carry an extra wrap bit, so a level of exactly FIFO_DEPTH sets its MSB.
  assign w_level = r_wrPtr - r_rdPtr;
  assign w_empty = (r_wrPtr == r_rdPtr);
  assign w_full  = w_level[PW];
  assign w_head  = r_mem[r_rdPtr[PW-1:0]];
  assign w_issue = (r_state == S_LOAD) & ~w_empty & ~i_host_wr;
  assign w_push  = i_fifo_wr & (~w_full | w_issue);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) r_mem[i] <= '0;
    end else if (w_ctrlAbort) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wrPtr[PW-1:0]] <= i_fifo_wdata;
        r_wrPtr <= r_wrPtr + 1'b1;
      end
      if (w_issue) r_rdPtr <= r_rdPtr + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (w_ctrlStart) w_next = (i_ctrl_wdata[13:8] == 6'd0) ? S_RELEASE : S_HOLD;
      S_HOLD:    if (r_holdCnt == HOLD_LAST) w_next = S_LOAD;
      S_LOAD:    if (w_issue && r_remaining == 6'd1) w_next = S_RELEASE;
      S_RELEASE: w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (w_ctrlAbort) w_next = S_IDLE;
  end

  // Sticky bits are cleared first so that a same-cycle set always wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_curAddr   <= '0;
      r_remaining <= '0;
      r_holdCnt   <= '0;
      r_autoEn    <= 1'b0;
      r_enable    <= 1'b0;
      r_done      <= 1'b0;
      r_overflow  <= 1'b0;
      r_startErr  <= 1'b0;
    end else begin
      if (w_ctrlClr) begin
        r_done     <= 1'b0;
        r_startErr <= 1'b0;
        r_overflow <= 1'b0;
      end
      if (i_fifo_wr && w_full && !w_issue) r_overflow <= 1'b1;
      if (w_ctrlStart && w_busy) r_startErr <= 1'b1;
      r_holdCnt <= (r_state == S_HOLD) ? r_holdCnt + HW'(1) : '0;
      if (r_state == S_IDLE && w_ctrlStart) begin
        r_curAddr   <= {i_ctrl_wdata[ADDR_W-1:2], 2'b00};
        r_remaining <= i_ctrl_wdata[13:8];
        r_autoEn    <= i_ctrl_wdata[16];
        r_enable    <= 1'b0;
      end
      if (w_issue) begin
        r_curAddr   <= r_curAddr + ADDR_STEP;
        r_remaining <= r_remaining - 6'd1;
      end
      if (r_state == S_RELEASE && !w_ctrlAbort) begin
        r_enable <= r_autoEn;
        r_done   <= 1'b1;
      end
    end
  end

  always_comb begin
    o_dbg_wr    = i_host_wr | w_issue;
    o_dbg_addr  = i_host_wr ? i_host_addr  : r_curAddr;
    o_dbg_wdata = i_host_wr ? i_host_wdata : w_head;
  end

  assign o_prism_reset_req  = (r_state == S_HOLD) | (r_state == S_LOAD);
  assign o_prism_enable_req = r_enable;
  assign o_done_irq         = r_done;

  always_comb begin
    o_status                 = '0;
    o_status[0]              = w_busy;
    o_status[1]              = r_done;
    o_status[2]              = r_overflow;
    o_status[3]              = r_startErr;
    o_status[4 +: PW+1]      = w_level;
    o_status[13:8]           = r_remaining;
    o_status[16 +: ADDR_W]   = r_curAddr;
    o_status[26:24]          = {1'b0, r_state};
  end

endmodule

// File: tb/tb_prism_cfg_sequencer.sv
// Self-checking bench for prism_cfg_sequencer: directed scenarios plus randomized
// bursts compared against a queue-based model of the expected debug-port traffic.

module tb_prism_cfg_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  i_host_addr = '0;
  logic [31:0] i_host_wdata = '0;
  logic        i_host_wr = 1'b0;
  logic        i_ctrl_wr = 1'b0;
  logic [31:0] i_ctrl_wdata = '0;
  logic        i_fifo_wr = 1'b0;
  logic [31:0] i_fifo_wdata = '0;
  logic [31:0] o_status;
  logic [5:0]  o_dbg_addr;
  logic [31:0] o_dbg_wdata;
  logic        o_dbg_wr, o_prism_reset_req, o_prism_enable_req, o_done_irq;

  prism_cfg_sequencer #(.FIFO_DEPTH(4), .ADDR_W(6), .HOLD_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_host_addr(i_host_addr), .i_host_wdata(i_host_wdata), .i_host_wr(i_host_wr),
    .i_ctrl_wr(i_ctrl_wr), .i_ctrl_wdata(i_ctrl_wdata),
    .i_fifo_wr(i_fifo_wr), .i_fifo_wdata(i_fifo_wdata),
    .o_status(o_status), .o_dbg_addr(o_dbg_addr), .o_dbg_wdata(o_dbg_wdata),
    .o_dbg_wr(o_dbg_wr), .o_prism_reset_req(o_prism_reset_req),
    .o_prism_enable_req(o_prism_enable_req), .o_done_irq(o_done_irq)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cyc;
    logic [5:0]  addr;
    logic [31:0] data;
    bit          host;
  } wr_t;

  int  checks = 0;
  int  errors = 0;
  int  cycle = 0;
  int  ctrlCycle = 0;
  int  resetCycles = 0;
  wr_t wlog[$];

  // Everything observed on the debug port is logged mid-cycle, when inputs and outputs are settled.
  always @(negedge clk) begin
    if (rst_n) begin
      if (o_dbg_wr) wlog.push_back('{cycle, o_dbg_addr, o_dbg_wdata, i_host_wr});
      if (o_prism_reset_req) resetCycles++;
      if (i_ctrl_wr) ctrlCycle = cycle;
      cycle++;
    end
  end

  initial begin
    #400000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [31:0] mkCtrl(bit st, bit ab, bit clr, bit ae, logic [5:0] n, logic [5:0] a);
    mkCtrl = {st, ab, clr, 12'b0, ae, 2'b0, n, 2'b0, a};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushWord(input logic [31:0] d);
    i_fifo_wr = 1'b1; i_fifo_wdata = d;
    tick();
    i_fifo_wr = 1'b0;
  endtask

  task automatic ctrlWrite(input logic [31:0] w);
    i_ctrl_wr = 1'b1; i_ctrl_wdata = w;
    tick();
    i_ctrl_wr = 1'b0; i_ctrl_wdata = '0;
  endtask

  task automatic hostWrite(input logic [5:0] a, input logic [31:0] d);
    i_host_wr = 1'b1; i_host_addr = a; i_host_wdata = d;
    tick();
    i_host_wr = 1'b0;
  endtask

  task automatic test_reset();
    $display("[TB] test_reset");
    checks++; if (o_status !== 32'h0) begin errors++; $display("[TB] FAIL reset_status: got %h required %h", o_status, 32'h0); end
    checks++; if (o_dbg_wr !== 1'b0) begin errors++; $display("[TB] FAIL reset_dbg_wr: got %b required 0", o_dbg_wr); end
    checks++; if (o_dbg_addr !== 6'h0 || o_dbg_wdata !== 32'h0) begin errors++; $display("[TB] FAIL reset_dbg_bus: got %h/%h required 0/0", o_dbg_addr, o_dbg_wdata); end
    checks++; if ({o_prism_reset_req, o_prism_enable_req, o_done_irq} !== 3'b000) begin errors++; $display("[TB] FAIL reset_flags: got %b required 000", {o_prism_reset_req, o_prism_enable_req, o_done_irq}); end
  endtask

  task automatic test_burst();
    logic [31:0] w[3];
    int lb, rb;
    $display("[TB] test_burst");
    for (int i = 0; i < 3; i++) w[i] = $urandom;
    lb = wlog.size();
    for (int i = 0; i < 3; i++) pushWord(w[i]);
    rb = resetCycles;
    ctrlWrite(mkCtrl(1, 0, 0, 1, 6'd3, 6'h10));
    for (int k = 0; k < 40 && o_done_irq !== 1'b1; k++) tick();
    checks++; if (o_done_irq !== 1'b1) begin errors++; $display("[TB] FAIL burst_done: got %b required 1", o_done_irq); end
    checks++; if (wlog.size() - lb !== 3) begin errors++; $display("[TB] FAIL burst_count: got %0d required 3", wlog.size() - lb); end
    for (int i = 0; i < 3 && lb + i < wlog.size(); i++) begin
      checks++;
      if (wlog[lb+i].addr !== 6'(16 + 4*i) || wlog[lb+i].data !== w[i] || wlog[lb+i].cyc !== ctrlCycle + 3 + i) begin
        errors++;
        $display("[TB] FAIL burst_write%0d: got %h@%h cyc %0d required %h@%h cyc %0d", i,
                 wlog[lb+i].data, wlog[lb+i].addr, wlog[lb+i].cyc, w[i], 6'(16 + 4*i), ctrlCycle + 3 + i);
      end
    end
    checks++; if (resetCycles - rb !== 5) begin errors++; $display("[TB] FAIL burst_reset_cycles: got %0d required 5", resetCycles - rb); end
    checks++; if (o_prism_enable_req !== 1'b1) begin errors++; $display("[TB] FAIL burst_enable: got %b required 1", o_prism_enable_req); end
    checks++; if (o_status[0] !== 1'b0 || o_status[26:24] !== 3'd0) begin errors++; $display("[TB] FAIL burst_idle: got busy %b state %0d required 0/0", o_status[0], o_status[26:24]); end
  endtask

  task automatic test_stall_wrap();
    logic [31:0] w[3];
    logic [5:0]  expA[3];
    int lb;
    $display("[TB] test_stall_wrap");
    expA[0] = 6'h38; expA[1] = 6'h3C; expA[2] = 6'h00;
    ctrlWrite(mkCtrl(0, 0, 1, 0, 6'd0, 6'd0));
    lb = wlog.size();
    ctrlWrite(mkCtrl(1, 0, 0, 0, 6'd3, 6'h38));
    repeat (6) tick();
    checks++; if (wlog.size() !== lb) begin errors++; $display("[TB] FAIL stall_no_write: got %0d writes required 0", wlog.size() - lb); end
    checks++; if (o_status[26:24] !== 3'd2 || o_status[13:8] !== 6'd3) begin errors++; $display("[TB] FAIL stall_state: got state %0d rem %0d required 2/3", o_status[26:24], o_status[13:8]); end
    for (int i = 0; i < 3; i++) begin
      w[i] = $urandom;
      pushWord(w[i]);
      repeat (3) tick();
    end
    for (int k = 0; k < 40 && o_done_irq !== 1'b1; k++) tick();
    checks++; if (o_done_irq !== 1'b1) begin errors++; $display("[TB] FAIL stall_done: got %b required 1", o_done_irq); end
    checks++; if (wlog.size() - lb !== 3) begin errors++; $display("[TB] FAIL stall_count: got %0d required 3", wlog.size() - lb); end
    for (int i = 0; i < 3 && lb + i < wlog.size(); i++) begin
      checks++;
      if (wlog[lb+i].addr !== expA[i] || wlog[lb+i].data !== w[i] || (i > 0 && wlog[lb+i].cyc - wlog[lb+i-1].cyc !== 4)) begin
        errors++;
        $display("[TB] FAIL stall_write%0d: got %h@%h cyc %0d required %h@%h", i, wlog[lb+i].data, wlog[lb+i].addr, wlog[lb+i].cyc, w[i], expA[i]);
      end
    end
    checks++; if (o_prism_enable_req !== 1'b0) begin errors++; $display("[TB] FAIL stall_enable: got %b required 0", o_prism_enable_req); end
  endtask

  task automatic test_host_collision();
    logic [31:0] x, y, hd;
    logic [5:0]  ha;
    int lb;
    $display("[TB] test_host_collision");
    x = $urandom; y = $urandom; hd = $urandom; ha = 6'($urandom_range(0, 63));
    ctrlWrite(mkCtrl(0, 0, 1, 0, 6'd0, 6'd0));
    lb = wlog.size();
    pushWord(x);
    pushWord(y);
    ctrlWrite(mkCtrl(1, 0, 0, 0, 6'd2, 6'h20));
    tick();
    tick();
    hostWrite(ha, hd);
    for (int k = 0; k < 40 && o_done_irq !== 1'b1; k++) tick();
    checks++; if (wlog.size() - lb !== 3) begin errors++; $display("[TB] FAIL collide_count: got %0d required 3", wlog.size() - lb); end
    if (wlog.size() - lb >= 3) begin
      checks++;
      if (!wlog[lb].host || wlog[lb].addr !== ha || wlog[lb].data !== hd || wlog[lb].cyc !== ctrlCycle + 3) begin
        errors++; $display("[TB] FAIL collide_host: got %h@%h cyc %0d required %h@%h cyc %0d", wlog[lb].data, wlog[lb].addr, wlog[lb].cyc, hd, ha, ctrlCycle + 3);
      end
      checks++;
      if (wlog[lb+1].addr !== 6'h20 || wlog[lb+1].data !== x || wlog[lb+1].cyc !== ctrlCycle + 4) begin
        errors++; $display("[TB] FAIL collide_delayed: got %h@%h cyc %0d required %h@20 cyc %0d", wlog[lb+1].data, wlog[lb+1].addr, wlog[lb+1].cyc, x, ctrlCycle + 4);
      end
      checks++;
      if (wlog[lb+2].addr !== 6'h24 || wlog[lb+2].data !== y || wlog[lb+2].cyc !== ctrlCycle + 5) begin
        errors++; $display("[TB] FAIL collide_second: got %h@%h cyc %0d required %h@24 cyc %0d", wlog[lb+2].data, wlog[lb+2].addr, wlog[lb+2].cyc, y, ctrlCycle + 5);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] w[5];
    int lb;
    $display("[TB] test_back_to_back");
    ctrlWrite(mkCtrl(0, 0, 1, 0, 6'd0, 6'd0));
    lb = wlog.size();
    for (int i = 0; i < 5; i++) w[i] = $urandom;
    for (int i = 0; i < 4; i++) pushWord(w[i]);
    ctrlWrite(mkCtrl(1, 0, 0, 0, 6'd5, 6'h04));
    tick();
    tick();
    pushWord(w[4]);
    for (int k = 0; k < 40 && o_done_irq !== 1'b1; k++) tick();
    checks++; if (wlog.size() - lb !== 5) begin errors++; $display("[TB] FAIL b2b_count: got %0d required 5", wlog.size() - lb); end
    for (int i = 0; i < 5 && lb + i < wlog.size(); i++) begin
      checks++;
      if (wlog[lb+i].addr !== 6'(4 + 4*i) || wlog[lb+i].data !== w[i] || wlog[lb+i].cyc !== ctrlCycle + 3 + i) begin
        errors++; $display("[TB] FAIL b2b_write%0d: got %h@%h cyc %0d required %h@%h cyc %0d", i, wlog[lb+i].data, wlog[lb+i].addr, wlog[lb+i].cyc, w[i], 6'(4 + 4*i), ctrlCycle + 3 + i);
      end
    end
    checks++; if (o_status[2] !== 1'b0) begin errors++; $display("[TB] FAIL b2b_overflow: got %b required 0", o_status[2]); end
  endtask

  task automatic test_overflow();
    logic [31:0] w[5];
    int lb;
    $display("[TB] test_overflow");
    ctrlWrite(mkCtrl(0, 0, 1, 0, 6'd0, 6'd0));
    lb = wlog.size();
    for (int i = 0; i < 5; i++) begin
      w[i] = $urandom;
      pushWord(w[i]);
    end
    checks++; if (o_status[2] !== 1'b1 || o_status[7:4] !== 4'd4) begin errors++; $display("[TB] FAIL ovf_set: got ovf %b level %0d required 1/4", o_status[2], o_status[7:4]); end
    ctrlWrite(mkCtrl(0, 0, 1, 0, 6'd0, 6'd0));
    checks++; if (o_status[2] !== 1'b0 || o_status[7:4] !== 4'd4) begin errors++; $display("[TB] FAIL ovf_clear: got ovf %b level %0d required 0/4", o_status[2], o_status[7:4]); end
    ctrlWrite(mkCtrl(1, 0, 0, 0, 6'd4, 6'h00));
    for (int k = 0; k < 40 && o_done_irq !== 1'b1; k++) tick();
    checks++; if (wlog.size() - lb !== 4) begin errors++; $display("[TB] FAIL ovf_drain_count: got %0d required 4", wlog.size() - lb); end
    for (int i = 0; i < 4 && lb + i < wlog.size(); i++) begin
      checks++;
      if (wlog[lb+i].data !== w[i] || wlog[lb+i].addr !== 6'(4*i)) begin
        errors++; $display("[TB] FAIL ovf_drain%0d: got %h@%h required %h@%h", i, wlog[lb+i].data, wlog[lb+i].addr, w[i], 6'(4*i));
      end
    end
  endtask

  task automatic test_start_err_abort();
    logic [31:0] w;
    int lb;
    $display("[TB] test_start_err_abort");
    ctrlWrite(mkCtrl(0, 0, 1, 0, 6'd0, 6'd0));
    lb = wlog.size();
    w = $urandom;
    pushWord(w);
    ctrlWrite(mkCtrl(1, 0, 0, 1, 6'd4, 6'h08));
    repeat (5) tick();
    checks++; if (wlog.size() - lb !== 1 || (wlog.size() > lb && (wlog[lb].addr !== 6'h08 || wlog[lb].data !== w))) begin errors++; $display("[TB] FAIL serr_first_write: got %0d writes required one %h@08", wlog.size() - lb, w); end
    ctrlWrite(mkCtrl(1, 0, 0, 0, 6'd1, 6'h30));
    checks++; if (o_status[3] !== 1'b1) begin errors++; $display("[TB] FAIL serr_set: got %b required 1", o_status[3]); end
    checks++; if (o_status[26:24] !== 3'd2 || o_status[13:8] !== 6'd3 || o_status[21:16] !== 6'h0C) begin errors++; $display("[TB] FAIL serr_unaffected: got state %0d rem %0d addr %h required 2/3/0c", o_status[26:24], o_status[13:8], o_status[21:16]); end
    ctrlWrite(mkCtrl(0, 1, 0, 0, 6'd0, 6'd0));
    checks++; if (o_status[26:24] !== 3'd0 || o_status[7:4] !== 4'd0 || o_prism_reset_req !== 1'b0 || o_done_irq !== 1'b0) begin errors++; $display("[TB] FAIL abort_state: got state %0d level %0d rst %b done %b required 0/0/0/0", o_status[26:24], o_status[7:4], o_prism_reset_req, o_done_irq); end
    ctrlWrite(mkCtrl(0, 0, 1, 0, 6'd0, 6'd0));
    checks++; if (o_status[3] !== 1'b0) begin errors++; $display("[TB] FAIL serr_clear: got %b required 0", o_status[3]); end
  endtask

  task automatic test_abort_flush();
    int lb;
    $display("[TB] test_abort_flush");
    ctrlWrite(mkCtrl(1, 0, 1, 1, 6'd0, 6'h00));
    for (int k = 0; k < 10 && o_done_irq !== 1'b1; k++) tick();
    ctrlWrite(mkCtrl(0, 1, 1, 0, 6'd0, 6'd0));
    checks++; if (o_prism_enable_req !== 1'b1) begin errors++; $display("[TB] FAIL abort_keeps_enable: got %b required 1", o_prism_enable_req); end
    lb = wlog.size();
    for (int i = 0; i < 3; i++) pushWord($urandom);
    ctrlWrite(mkCtrl(1, 1, 0, 0, 6'd3, 6'h00));
    checks++; if (o_status[0] !== 1'b0 || o_status[7:4] !== 4'd0) begin errors++; $display("[TB] FAIL abort_wins_start: got busy %b level %0d required 0/0", o_status[0], o_status[7:4]); end
    for (int i = 0; i < 3; i++) pushWord($urandom);
    ctrlWrite(mkCtrl(1, 0, 0, 0, 6'd3, 6'h00));
    ctrlWrite(mkCtrl(0, 1, 0, 0, 6'd0, 6'd0));
    repeat (4) tick();
    checks++; if (o_status[7:4] !== 4'd0 || o_status[26:24] !== 3'd0 || o_prism_reset_req !== 1'b0) begin errors++; $display("[TB] FAIL flush_state: got level %0d state %0d rst %b required 0/0/0", o_status[7:4], o_status[26:24], o_prism_reset_req); end
    checks++; if (wlog.size() !== lb || o_done_irq !== 1'b0) begin errors++; $display("[TB] FAIL flush_no_write: got %0d writes done %b required 0/0", wlog.size() - lb, o_done_irq); end
  endtask

  task automatic test_random_bursts();
    logic [5:0]  a, n, expA;
    bit          ae;
    logic [31:0] expQ[$];
    wr_t         hostQ[$];
    logic [31:0] hd;
    logic [5:0]  ha;
    int lb, li, hi, gap;
    $display("[TB] test_random_bursts");
    for (int it = 0; it < 6; it++) begin
      a = 6'($urandom_range(0, 63)); n = 6'($urandom_range(1, 6)); ae = 1'($urandom_range(0, 1));
      expQ.delete(); hostQ.delete();
      ctrlWrite(mkCtrl(0, 0, 1, 0, 6'd0, 6'd0));
      lb = wlog.size();
      ctrlWrite(mkCtrl(1, 0, 0, ae, n, a));
      for (int i = 0; i < int'(n); i++) begin
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
          if ($urandom_range(0, 3) == 0) begin
            ha = 6'($urandom_range(0, 63)); hd = $urandom;
            hostQ.push_back('{0, ha, hd, 1'b1});
            hostWrite(ha, hd);
          end else tick();
        end
        expQ.push_back($urandom);
        pushWord(expQ[expQ.size()-1]);
      end
      for (int k = 0; k < 60 && o_done_irq !== 1'b1; k++) tick();
      checks++; if (o_done_irq !== 1'b1) begin errors++; $display("[TB] FAIL rand%0d_done: got %b required 1", it, o_done_irq); end
      li = 0; hi = 0;
      for (int j = lb; j < wlog.size(); j++) begin
        if (wlog[j].host) begin
          if (hi < hostQ.size()) begin
            checks++;
            if (wlog[j].addr !== hostQ[hi].addr || wlog[j].data !== hostQ[hi].data) begin errors++; $display("[TB] FAIL rand%0d_host%0d: got %h@%h required %h@%h", it, hi, wlog[j].data, wlog[j].addr, hostQ[hi].data, hostQ[hi].addr); end
          end
          hi++;
        end else begin
          expA = (a & 6'h3C) + 6'(4*li);
          if (li < expQ.size()) begin
            checks++;
            if (wlog[j].addr !== expA || wlog[j].data !== expQ[li]) begin errors++; $display("[TB] FAIL rand%0d_load%0d: got %h@%h required %h@%h", it, li, wlog[j].data, wlog[j].addr, expQ[li], expA); end
          end
          li++;
        end
      end
      checks++; if (li !== int'(n) || hi !== hostQ.size()) begin errors++; $display("[TB] FAIL rand%0d_counts: got %0d/%0d required %0d/%0d", it, li, hi, n, hostQ.size()); end
      checks++; if (o_prism_enable_req !== ae) begin errors++; $display("[TB] FAIL rand%0d_enable: got %b required %b", it, o_prism_enable_req, ae); end
    end
  endtask

  task automatic test_async_reset();
    int lb;
    $display("[TB] test_async_reset");
    pushWord($urandom);
    ctrlWrite(mkCtrl(1, 0, 0, 0, 6'd3, 6'h00));
    repeat (5) tick();
    checks++; if (o_dbg_addr !== 6'h04 || o_prism_reset_req !== 1'b1) begin errors++; $display("[TB] FAIL areset_pre: got addr %h rst %b required 04/1", o_dbg_addr, o_prism_reset_req); end
    #3 rst_n = 1'b0;
    #1;
    checks++; if (o_status !== 32'h0 || o_dbg_wr !== 1'b0 || o_dbg_addr !== 6'h0 || o_dbg_wdata !== 32'h0) begin errors++; $display("[TB] FAIL areset_outputs: got status %h wr %b addr %h data %h required all 0", o_status, o_dbg_wr, o_dbg_addr, o_dbg_wdata); end
    checks++; if ({o_prism_reset_req, o_prism_enable_req, o_done_irq} !== 3'b000) begin errors++; $display("[TB] FAIL areset_flags: got %b required 000", {o_prism_reset_req, o_prism_enable_req, o_done_irq}); end
    #2 rst_n = 1'b1;
    tick();
    lb = wlog.size();
    ctrlWrite(mkCtrl(1, 0, 0, 1, 6'd0, 6'h14));
    for (int k = 0; k < 10 && o_done_irq !== 1'b1; k++) tick();
    checks++; if (o_done_irq !== 1'b1 || o_prism_enable_req !== 1'b1 || o_status[0] !== 1'b0) begin errors++; $display("[TB] FAIL zero_len_done: got done %b en %b busy %b required 1/1/0", o_done_irq, o_prism_enable_req, o_status[0]); end
    checks++; if (wlog.size() !== lb) begin errors++; $display("[TB] FAIL zero_len_writes: got %0d required 0", wlog.size() - lb); end
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    #3 rst_n = 1'b1;
    tick();
    test_burst();
    test_stall_wrap();
    test_host_collision();
    test_back_to_back();
    test_overflow();
    test_start_err_abort();
    test_abort_flush();
    test_random_bursts();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
